// File: rtl/lcd_frame_serializer.sv
// Snapshots the user design's debug/display outputs on a start pulse and streams
// them to the host as a fixed 62-byte frame over valid/ready, closed by an XOR checksum.
module lcd_frame_serializer #(
    parameter int          NBITS_TOP   = 8,
    parameter int          NREGS_TOP   = 32,
    parameter int          NBITS_LCD   = 64,
    parameter int          NINSTR_BITS = 32,
    parameter logic [7:0]  HEADER      = 8'hA5
) (
    input  logic                   clk_2,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NBITS_TOP-1:0]   lcd_pc,
    input  logic [NBITS_TOP-1:0]   lcd_SrcA,
    input  logic [NBITS_TOP-1:0]   lcd_SrcB,
    input  logic [NBITS_TOP-1:0]   lcd_ALUResult,
    input  logic [NBITS_TOP-1:0]   lcd_Result,
    input  logic [NBITS_TOP-1:0]   lcd_WriteData,
    input  logic [NBITS_TOP-1:0]   lcd_ReadData,
    input  logic [NINSTR_BITS-1:0] lcd_instruction,
    input  logic                   lcd_MemWrite,
    input  logic                   lcd_Branch,
    input  logic                   lcd_MemtoReg,
    input  logic                   lcd_RegWrite,
    input  logic [NBITS_TOP-1:0]   lcd_registrador [0:NREGS_TOP-1],
    input  logic [NBITS_LCD-1:0]   lcd_a,
    input  logic [NBITS_LCD-1:0]   lcd_b,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    localparam int INSTR_BYTES = NINSTR_BITS / 8;
    localparam int LCD_BYTES   = NBITS_LCD / 8;
    localparam int OFF_INSTR   = 2;
    localparam int OFF_DP      = OFF_INSTR + INSTR_BYTES;
    localparam int OFF_FLAGS   = OFF_DP + 6;
    localparam int OFF_REGS    = OFF_FLAGS + 1;
    localparam int OFF_LA      = OFF_REGS + NREGS_TOP;
    localparam int OFF_LB      = OFF_LA + LCD_BYTES;
    localparam int OFF_CSUM    = OFF_LB + LCD_BYTES;
    localparam int FRAME_BYTES = OFF_CSUM + 1;
    localparam int IDX_W       = $clog2(FRAME_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       csum_q, csum_d;
    logic             done_q, done_d;
    logic             capture;
    logic [7:0]       byte_sel;

    logic [7:0] frame_bytes [0:FRAME_BYTES-1];
    logic [7:0] snap_q      [0:FRAME_BYTES-1];

    // Live frame image; only copied into snap_q at the moment a frame is accepted.
    assign frame_bytes[0]         = HEADER;
    assign frame_bytes[1]         = lcd_pc;
    assign frame_bytes[OFF_DP+0]  = lcd_SrcA;
    assign frame_bytes[OFF_DP+1]  = lcd_SrcB;
    assign frame_bytes[OFF_DP+2]  = lcd_ALUResult;
    assign frame_bytes[OFF_DP+3]  = lcd_Result;
    assign frame_bytes[OFF_DP+4]  = lcd_WriteData;
    assign frame_bytes[OFF_DP+5]  = lcd_ReadData;
    assign frame_bytes[OFF_FLAGS] = {4'b0000, lcd_MemWrite, lcd_Branch, lcd_MemtoReg, lcd_RegWrite};
    // Checksum slot is filled from the running accumulator, not the snapshot.
    assign frame_bytes[OFF_CSUM]  = 8'h00;

    generate
        for (genvar gi = 0; gi < INSTR_BYTES; gi++) begin : g_instr
            assign frame_bytes[OFF_INSTR+gi] = lcd_instruction[NINSTR_BITS-1-8*gi -: 8];
        end
        for (genvar gi = 0; gi < NREGS_TOP; gi++) begin : g_regs
            assign frame_bytes[OFF_REGS+gi] = lcd_registrador[gi];
        end
        for (genvar gi = 0; gi < LCD_BYTES; gi++) begin : g_lcd
            assign frame_bytes[OFF_LA+gi] = lcd_a[NBITS_LCD-1-8*gi -: 8];
            assign frame_bytes[OFF_LB+gi] = lcd_b[NBITS_LCD-1-8*gi -: 8];
        end
        for (genvar gi = 0; gi < FRAME_BYTES; gi++) begin : g_snap
            always_ff @(posedge clk_2) begin
                if (capture) begin
                    snap_q[gi] <= frame_bytes[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            csum_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        done_d    = 1'b0;
        capture   = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        byte_sel  = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    csum_d  = 8'h00;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_last  = (idx_q == LAST_IDX);
                byte_sel  = out_last ? csum_q : snap_q[idx_q];
                if (out_ready) begin
                    csum_d = csum_q ^ byte_sel;
                    if (out_last) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_data = byte_sel;
    assign busy     = (state_q == S_SEND);
    assign done     = done_q;

endmodule

// File: tb/tb_lcd_frame_serializer.sv
// Directed bench for lcd_frame_serializer: reset, frame contents, backpressure,
// snapshot freezing and back-to-back frames.
module tb_lcd_frame_serializer;

    localparam int NR = 32;

    logic        clk_2 = 1'b0;
    logic        reset, start, out_ready;
    logic [7:0]  lcd_pc, lcd_SrcA, lcd_SrcB, lcd_ALUResult, lcd_Result, lcd_WriteData, lcd_ReadData;
    logic [31:0] lcd_instruction;
    logic        lcd_MemWrite, lcd_Branch, lcd_MemtoReg, lcd_RegWrite;
    logic [7:0]  lcd_registrador [0:NR-1];
    logic [63:0] lcd_a, lcd_b;
    logic [7:0]  out_data;
    logic        out_valid, out_last, busy, done;

    logic [7:0]  got_b [0:61];
    logic [7:0]  ref_b [0:61];
    int          checks = 0;
    int          errors = 0;
    int          cyc;

    always #5 clk_2 = ~clk_2;

    lcd_frame_serializer dut (
        .clk_2(clk_2), .reset(reset), .start(start),
        .lcd_pc(lcd_pc), .lcd_SrcA(lcd_SrcA), .lcd_SrcB(lcd_SrcB),
        .lcd_ALUResult(lcd_ALUResult), .lcd_Result(lcd_Result),
        .lcd_WriteData(lcd_WriteData), .lcd_ReadData(lcd_ReadData),
        .lcd_instruction(lcd_instruction),
        .lcd_MemWrite(lcd_MemWrite), .lcd_Branch(lcd_Branch),
        .lcd_MemtoReg(lcd_MemtoReg), .lcd_RegWrite(lcd_RegWrite),
        .lcd_registrador(lcd_registrador), .lcd_a(lcd_a), .lcd_b(lcd_b),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic zero_inputs();
        {lcd_pc, lcd_SrcA, lcd_SrcB, lcd_ALUResult, lcd_Result, lcd_WriteData, lcd_ReadData} = '0;
        lcd_instruction = '0;
        {lcd_MemWrite, lcd_Branch, lcd_MemtoReg, lcd_RegWrite} = 4'b0000;
        for (int i = 0; i < NR; i++) lcd_registrador[i] = 8'h00;
        lcd_a = '0;
        lcd_b = '0;
    endtask

    task automatic pattern_inputs();
        zero_inputs();
        lcd_pc          = 8'h12;
        lcd_instruction = 32'h34567890;
        lcd_SrcA        = 8'hAB;
        lcd_SrcB        = 8'hCD;
        lcd_MemWrite    = 1'b1;
        lcd_RegWrite    = 1'b1;
        lcd_registrador[5] = 8'h55;
        lcd_a           = 64'h1234567890ABCDFF;
    endtask

    task automatic ones_inputs();
        {lcd_pc, lcd_SrcA, lcd_SrcB, lcd_ALUResult, lcd_Result, lcd_WriteData, lcd_ReadData} = '1;
        lcd_instruction = '1;
        {lcd_MemWrite, lcd_Branch, lcd_MemtoReg, lcd_RegWrite} = 4'b1111;
        for (int i = 0; i < NR; i++) lcd_registrador[i] = 8'hFF;
        lcd_a = '1;
        lcd_b = '1;
    endtask

    // Pulses start, then collects bytes into got_b; cycles counts edges from start to done.
    task automatic do_frame(input string name, input int pct, input int change_at, output int cycles);
        int         n;
        int         stall_bad;
        logic       holding;
        logic       last_bad;
        logic [7:0] hold;
        n = 0; cycles = 0; stall_bad = 0; holding = 1'b0; last_bad = 1'b0; hold = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_hdr"}, {54'd0, out_valid, busy, out_data}, {54'd0, 1'b1, 1'b1, 8'hA5});
        while (n < 62 && cycles < 1000) begin
            if (cycles == change_at) begin
                ones_inputs();
                start = 1'b1;
            end
            if (cycles == change_at + 1) start = 1'b0;
            out_ready = ($urandom_range(99) < pct);
            if (holding && out_data !== hold) stall_bad++;
            if (out_valid !== 1'b1 || done !== 1'b0) stall_bad++;
            if (out_last !== (n == 61)) last_bad = 1'b1;
            holding = 1'b0;
            if (out_ready) begin
                got_b[n] = out_data;
                n++;
            end else begin
                holding = 1'b1;
                hold    = out_data;
            end
            tick();
            cycles++;
        end
        out_ready = 1'b0;
        check({name, "_count"}, 64'(n), 64'd62);
        check({name, "_stall"}, 64'(stall_bad), 64'd0);
        check({name, "_last"}, {63'd0, last_bad}, 64'd0);
        check({name, "_end"}, {61'd0, done, busy, out_valid}, {61'd0, 3'b100});
        $display("frame %s bytes=%0d cycles=%0d hdr=%02h csum=%02h", name, n, cycles, got_b[0], got_b[61]);
    endtask

    function automatic int diff_ref();
        int d = 0;
        for (int i = 0; i < 62; i++) if (got_b[i] !== ref_b[i]) d++;
        return d;
    endfunction

    initial begin
        int   nz;
        logic seen;
        logic [7:0] x;
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        zero_inputs();
        tick(); tick();
        check("reset_state", {59'd0, out_valid, out_last, busy, done, |out_data}, 64'd0);
        reset = 1'b0;
        tick();

        // Abort a frame part way through with a 2-cycle reset.
        start = 1'b1; tick(); start = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        check("rst_mid", {56'd0, out_valid, out_last, busy, done, 4'd0} | {56'd0, out_data}, 64'd0);
        seen = 1'b0;
        repeat (3) begin tick(); seen = seen | done | busy; end
        check("rst_no_done", {63'd0, seen}, 64'd0);
        $display("reset abort observed done_or_busy=%0b", seen);

        do_frame("zero", 100, -1, cyc);
        check("zero_cycles", 64'(cyc), 64'd62);
        check("zero_b0", {56'd0, got_b[0]}, 64'hA5);
        nz = 0;
        for (int i = 1; i <= 60; i++) if (got_b[i] != 8'h00) nz++;
        check("zero_payload", 64'(nz), 64'd0);
        check("zero_csum", {56'd0, got_b[61]}, 64'hA5);
        tick();
        check("zero_done_pulse", {63'd0, done}, 64'd0);

        pattern_inputs();
        do_frame("pat", 100, -1, cyc);
        check("pat_pc", {56'd0, got_b[1]}, 64'h12);
        check("pat_instr", {32'd0, got_b[2], got_b[3], got_b[4], got_b[5]}, 64'h34567890);
        check("pat_srcab", {48'd0, got_b[6], got_b[7]}, 64'hABCD);
        check("pat_flags", {56'd0, got_b[12]}, 64'h09);
        check("pat_reg5", {56'd0, got_b[18]}, 64'h55);
        check("pat_lcda", {got_b[45], got_b[46], got_b[47], got_b[48],
                           got_b[49], got_b[50], got_b[51], got_b[52]}, 64'h1234567890ABCDFF);
        check("pat_csum_hand", {56'd0, got_b[61]}, 64'h06);
        x = 8'h00;
        for (int i = 0; i <= 60; i++) x = x ^ got_b[i];
        check("pat_csum_xor", {56'd0, got_b[61]}, {56'd0, x});
        for (int i = 0; i < 62; i++) ref_b[i] = got_b[i];
        tick();

        do_frame("bp", 50, -1, cyc);
        check("bp_same", 64'(diff_ref()), 64'd0);
        check("bp_stalled", {63'd0, (cyc > 62)}, 64'd1);
        tick();

        pattern_inputs();
        do_frame("mid", 100, 10, cyc);
        check("mid_same", 64'(diff_ref()), 64'd0);
        check("mid_cycles", 64'(cyc), 64'd62);
        seen = 1'b0;
        repeat (5) begin tick(); seen = seen | busy | out_valid; end
        check("mid_no_second", {63'd0, seen}, 64'd0);

        pattern_inputs();
        do_frame("b2b1", 100, -1, cyc);
        do_frame("b2b2", 100, -1, cyc);
        check("b2b_same", 64'(diff_ref()), 64'd0);
        check("b2b_cycles", 64'(cyc), 64'd62);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
